// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - MIPS instruction-fetch stage: PC, imem handshake, delay-slot redirect, stall hold
// Optional misaligned-target trap enabled by defining IF_ALIGN_CHECK_EN (adds if_adel port).
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_valid
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic        if_adel
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_ADEL  = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_instr_q;
    logic        if_valid_q;
    logic [31:0] hold_pc_q;
    logic [31:0] hold_instr_q;
    logic        redir_pend_q;
    logic [31:0] redir_target_q;

    logic [31:0] tgt_w;
    logic        pc_ok_w;
    logic [31:0] next_pc_d;

`ifdef IF_ALIGN_CHECK_EN
    logic adel_q;

    assign tgt_w   = branch_target;
    assign pc_ok_w = (pc_q[1:0] == 2'b00);
    assign if_adel = adel_q;
`else
    logic [1:0] unused_tgt_lsb;

    assign unused_tgt_lsb = branch_target[1:0];
    assign tgt_w          = {branch_target[31:2], 2'b00};
    assign pc_ok_w        = 1'b1;
`endif

    // A same-cycle pulse beats an older pending target: the latest redirect wins.
    assign next_pc_d = branch_taken ? tgt_w :
                       redir_pend_q ? redir_target_q :
                       pc_q + 32'd4;

    assign imem_req  = rst_n && (state_q == S_FETCH) && pc_ok_w;
    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_valid  = if_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            if_pc_q        <= 32'h0;
            if_instr_q     <= 32'h0;
            if_valid_q     <= 1'b0;
            hold_pc_q      <= 32'h0;
            hold_instr_q   <= 32'h0;
            redir_pend_q   <= 1'b0;
            redir_target_q <= 32'h0;
`ifdef IF_ALIGN_CHECK_EN
            adel_q         <= 1'b0;
`endif
        end else begin
            // Remember any redirect; a completion below consumes it instead.
            if (branch_taken) begin
                redir_pend_q   <= 1'b1;
                redir_target_q <= tgt_w;
            end
            case (state_q)
                S_FETCH: begin
`ifdef IF_ALIGN_CHECK_EN
                    if (!pc_ok_w) begin
                        if (!stall) begin
                            if_pc_q    <= pc_q;
                            if_instr_q <= 32'h0;
                            if_valid_q <= 1'b0;
                            adel_q     <= 1'b1;
                            state_q    <= S_ADEL;
                        end
                    end else
`endif
                    if (imem_ready) begin
                        pc_q         <= next_pc_d;
                        redir_pend_q <= 1'b0;
                        if (stall) begin
                            hold_pc_q    <= pc_q;
                            hold_instr_q <= imem_rdata;
                            state_q      <= S_HOLD;
                        end else begin
                            if_pc_q    <= pc_q;
                            if_instr_q <= imem_rdata;
                            if_valid_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_instr_q <= 32'h0;
                        if_valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_pc_q    <= hold_pc_q;
                        if_instr_q <= hold_instr_q;
                        if_valid_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
`ifdef IF_ALIGN_CHECK_EN
                S_ADEL: begin
                    // Parked until ID supplies a usable (word-aligned) target.
                    if (branch_taken) begin
                        redir_pend_q <= 1'b0;
                        if (tgt_w[1:0] == 2'b00) begin
                            pc_q    <= tgt_w;
                            adel_q  <= 1'b0;
                            state_q <= S_FETCH;
                        end else begin
                            if_pc_q <= tgt_w;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch: vector table, corner sequences, random vs model
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    wire         imem_req;
    wire  [31:0] imem_addr;
    wire  [31:0] if_pc;
    wire  [31:0] if_instr;
    wire         if_valid;
`ifdef IF_ALIGN_CHECK_EN
    wire         if_adel;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_valid      (if_valid)
`ifdef IF_ALIGN_CHECK_EN
        ,
        .if_adel       (if_adel)
`endif
    );

    typedef struct packed {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic        valid;
    } vec_t;

    vec_t tbl [21];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:16] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and return 1 ns after the edge.
    task automatic step(input logic s, input logic br, input logic [31:0] tgt, input logic rdy);
        stall         = s;
        branch_taken  = br;
        branch_target = tgt;
        imem_ready    = rdy;
        imem_rdata    = mem_word(imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [31:0] pc, input logic valid);
        check({name, ".if_pc"}, if_pc, pc);
        check({name, ".if_valid"}, {31'h0, if_valid}, {31'h0, valid});
        check({name, ".if_instr"}, if_instr, valid ? mem_word(pc) : 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst.req_low", {31'h0, imem_req}, 32'h0);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [31:0] exp_q [$];
        logic [31:0] model_next;
        logic [31:0] pend_tgt;
        logic        pend;
        logic        prev_wait;
        logic [31:0] prev_addr;
        logic [31:0] p_pc;
        logic [31:0] p_instr;
        logic        p_valid;
        logic        s, br, rdy, done;
        logic [31:0] tgt;
        logic [31:0] got;

        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;

        tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h0,        1'b1};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        32'h4,        1'b1};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        32'h8,        1'b1};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hC,        32'h8,        1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h100,      1'b0, 1'b1, 32'hC,        32'h8,        1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100,      32'hC,        1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h104,      32'h100,      1'b1};
        tbl[7]  = '{1'b0, 1'b1, 32'h200,      1'b1, 1'b1, 32'h200,      32'h104,      1'b1};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h204,      32'h200,      1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'h300,      1'b0, 1'b1, 32'h204,      32'h200,      1'b0};
        tbl[10] = '{1'b0, 1'b1, 32'h400,      1'b0, 1'b1, 32'h204,      32'h200,      1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h400,      32'h204,      1'b1};
        tbl[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h404,      32'h204,      1'b1};
        tbl[13] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h404,      32'h204,      1'b1};
        tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h404,      32'h400,      1'b1};
        tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h408,      32'h404,      1'b1};
        tbl[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h408,      32'h404,      1'b1};
        tbl[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h408,      32'h404,      1'b0};
        tbl[18] = '{1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 1'b1, 32'hFFFFFFFC, 32'h408,      1'b1};
        tbl[19] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,        32'hFFFFFFFC, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,        32'h0,        1'b1};

        // Reset state
        do_reset();
        check_out("reset", 32'h0, 1'b0);
        check("reset.req", {31'h0, imem_req}, 32'h1);
        check("reset.addr", imem_addr, 32'h0);

        // Vector table: zero-wait stream, redirects, stall/HOLD, address wrap
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].rdy);
            check($sformatf("vec%0d.req", i), {31'h0, imem_req}, {31'h0, tbl[i].req});
            check($sformatf("vec%0d.addr", i), imem_addr, tbl[i].addr);
            check_out($sformatf("vec%0d", i), tbl[i].pc, tbl[i].valid);
        end

        // Three wait states per word
        do_reset();
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 3; c++) begin
                step(1'b0, 1'b0, 32'h0, 1'b0);
                check($sformatf("wait%0d_%0d.req", w, c), {31'h0, imem_req}, 32'h1);
                check($sformatf("wait%0d_%0d.addr", w, c), imem_addr, 32'(w * 4));
                check($sformatf("wait%0d_%0d.valid", w, c), {31'h0, if_valid}, 32'h0);
                check($sformatf("wait%0d_%0d.instr", w, c), if_instr, 32'h0);
            end
            step(1'b0, 1'b0, 32'h0, 1'b1);
            check_out($sformatf("wait%0d_done", w), 32'(w * 4), 1'b1);
            check($sformatf("wait%0d_done.addr", w), imem_addr, 32'(w * 4 + 4));
        end

        // Reset while a fetch at 0x40 is outstanding
        do_reset();
        step(1'b0, 1'b1, 32'h40, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("midrst.addr_pre", imem_addr, 32'h40);
        rst_n = 1'b0;
        #1;
        check("midrst.req_comb", {31'h0, imem_req}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("midrst.req", {31'h0, imem_req}, 32'h0);
        check_out("midrst", 32'h0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("midrst.addr_post", imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("midrst.first", 32'h0, 1'b1);

        // Misaligned target 0x102
        do_reset();
        step(1'b0, 1'b1, 32'h102, 1'b1);
        check_out("mis.slot", 32'h0, 1'b1);
`ifdef IF_ALIGN_CHECK_EN
        check("mis.req", {31'h0, imem_req}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("mis.trap", 32'h102, 1'b0);
        check("mis.adel", {31'h0, if_adel}, 32'h1);
        check("mis.req_trap", {31'h0, imem_req}, 32'h0);
        step(1'b0, 1'b1, 32'h200, 1'b0);
        check("mis.adel_clr", {31'h0, if_adel}, 32'h0);
        check("mis.req_resume", {31'h0, imem_req}, 32'h1);
        check("mis.addr_resume", imem_addr, 32'h200);
`else
        check("mis.addr", imem_addr, 32'h100);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check_out("mis.fetch", 32'h100, 1'b1);
`endif

        // Randomised run against a delivery-order model
        do_reset();
        exp_q.delete();
        model_next = 32'h0;
        pend       = 1'b0;
        pend_tgt   = 32'h0;
        prev_wait  = 1'b0;
        prev_addr  = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            s   = (n < 2980) && ($urandom_range(0, 3) == 0);
            br  = (n < 2980) && ($urandom_range(0, 9) == 0);
            tgt = 32'($urandom_range(0, 1023)) << 2;
            rdy = ($urandom_range(0, 2) != 0);
            if (prev_wait) begin
                check("rnd.req_stable", {31'h0, imem_req}, 32'h1);
                check("rnd.addr_stable", imem_addr, prev_addr);
            end
            done = imem_req && rdy;
            if (done) begin
                check("rnd.fetch_addr", imem_addr, model_next);
                exp_q.push_back(imem_addr);
                model_next = br ? tgt : (pend ? pend_tgt : imem_addr + 32'd4);
                pend = 1'b0;
            end else if (br) begin
                pend     = 1'b1;
                pend_tgt = tgt;
            end
            prev_wait = imem_req && !rdy;
            prev_addr = imem_addr;
            p_pc = if_pc; p_instr = if_instr; p_valid = if_valid;
            step(s, br, tgt, rdy);
            if (s) begin
                check("rnd.hold_pc", if_pc, p_pc);
                check("rnd.hold_instr", if_instr, p_instr);
                check("rnd.hold_valid", {31'h0, if_valid}, {31'h0, p_valid});
            end else if (if_valid) begin
                if (exp_q.size() == 0) begin
                    check("rnd.spurious_valid", if_pc, 32'hDEAD_DEAD);
                end else begin
                    got = exp_q.pop_front();
                    check("rnd.pc", if_pc, got);
                    check("rnd.instr", if_instr, mem_word(got));
                end
            end else begin
                check("rnd.bubble_instr", if_instr, 32'h0);
            end
        end
        check("rnd.undelivered", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
